// File: rtl/game_control.sv
// game_control -- number-guessing round controller.
//
// Picks a pseudo-random secret from a free-running LFSR, drives a downstream
// countdown timer (restart / timer_digit), scores correct guesses by the time
// remaining, and reports win / lose / timeout.
//
// Ports
//   clk          in   system clock, rising-edge
//   reset        in   synchronous active-high reset
//   start        in   pulse: begin a round (ignored while Max_digit == 0)
//   Max_digit    in   [1:0] difficulty 1..3
//   guess        in   [6:0] player guess
//   guess_valid  in   pulse qualifying guess
//   counter      in   [6:0] seconds remaining from the timer
//   restart      out  active-low timer reload, low only in LOAD
//   timer_digit  out  [1:0] latched difficulty for the timer
//   hint_hi/lo   out  last wrong guess was above / below the secret
//   win/lose     out  round result, decoded from state
//   timeout      out  round lost because the timer ran out
//   attempts     out  [3:0] wrong guesses this round
//   score        out  [7:0] saturating accumulated score
//   secret       out  [6:0] current secret
module game_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] Max_digit,
  input  logic [6:0] guess,
  input  logic       guess_valid,
  input  logic [6:0] counter,
  output logic       restart,
  output logic [1:0] timer_digit,
  output logic       hint_hi,
  output logic       hint_lo,
  output logic       win,
  output logic       lose,
  output logic       timeout,
  output logic [3:0] attempts,
  output logic [7:0] score,
  output logic [6:0] secret
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] lfsr;
  logic [6:0] secret_pick;
  logic [3:0] attempts_inc;
  logic [8:0] score_sum;
  logic [7:0] score_sat;
  logic       begin_round;
  logic       hit;

  assign begin_round  = start && (Max_digit != 2'd0);
  assign hit          = (guess == secret);
  assign attempts_inc = attempts + 4'd1;
  assign score_sum    = {1'b0, score} + {2'b00, counter};
  assign score_sat    = score_sum[8] ? 8'hFF : score_sum[7:0];

  // Map the LFSR value onto the difficulty range; for the widest range,
  // values 100..127 fold down to 72..99.
  always_comb begin
    case (timer_digit)
      2'd1:    secret_pick = {3'b000, lfsr[3:0]};
      2'd2:    secret_pick = {1'b0, lfsr[5:0]};
      default: secret_pick = (lfsr > 7'd99) ? (lfsr - 7'd28) : lfsr;
    endcase
  end

  // Free-running LFSR; its value at the LOAD cycle seeds the secret.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) lfsr <= 7'h01;
    else       lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A correct guess beats an expiring timer, and any
  // guess_valid cycle is judged on the guess rather than on the timer.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      IDLE:     if (begin_round) state_next = LOAD;
      LOAD:     state_next = PLAY;
      PLAY: begin
        if (guess_valid) begin
          if (hit)                        state_next = WIN;
          else if (attempts_inc == 4'd8)  state_next = LOSE;
        end else if (counter == 7'd0) begin
          state_next = LOSE;
        end
      end
      WIN, LOSE: if (begin_round) state_next = LOAD;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from state.
  always_comb begin
    restart = (state != LOAD);
    win     = (state == WIN);
    lose    = (state == LOSE);
  end

  // Round datapath. Difficulty is captured on entry to LOAD so the timer
  // already sees it while restart is low; the secret is captured on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_digit <= 2'd0;
      secret      <= 7'd0;
      attempts    <= 4'd0;
      score       <= 8'd0;
      hint_hi     <= 1'b0;
      hint_lo     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (begin_round) begin
            timer_digit <= Max_digit;
            attempts    <= 4'd0;
            hint_hi     <= 1'b0;
            hint_lo     <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        LOAD: secret <= secret_pick;
        PLAY: begin
          if (guess_valid) begin
            if (hit) begin
              score <= score_sat;
            end else begin
              hint_hi  <= (guess > secret);
              hint_lo  <= (guess < secret);
              attempts <= attempts_inc;
            end
          end else if (counter == 7'd0) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control. Expectations are queued as each stimulus
// step is driven and compared after the clock edge that should produce them.
module tb_game_control;

  logic       clk = 1'b0;
  logic       reset, start, guess_valid;
  logic [1:0] Max_digit;
  logic [6:0] guess, counter;
  logic       restart, hint_hi, hint_lo, win, lose, timeout;
  logic [1:0] timer_digit;
  logic [3:0] attempts;
  logic [7:0] score;
  logic [6:0] secret;

  game_control dut (
    .clk(clk), .reset(reset), .start(start), .Max_digit(Max_digit),
    .guess(guess), .guess_valid(guess_valid), .counter(counter),
    .restart(restart), .timer_digit(timer_digit), .hint_hi(hint_hi),
    .hint_lo(hint_lo), .win(win), .lose(lose), .timeout(timeout),
    .attempts(attempts), .score(score), .secret(secret)
  );

  always #5 clk = ~clk;

  // Reference LFSR, advanced alongside the design.
  logic [6:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 7'h01;
    else       m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  typedef struct {
    string name;
    string sig;
    int    exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic int observe(string sig);
    case (sig)
      "restart":     return int'(restart);
      "timer_digit": return int'(timer_digit);
      "secret":      return int'(secret);
      "hint_hi":     return int'(hint_hi);
      "hint_lo":     return int'(hint_lo);
      "win":         return int'(win);
      "lose":        return int'(lose);
      "timeout":     return int'(timeout);
      "attempts":    return int'(attempts);
      "score":       return int'(score);
      default:       return -1;
    endcase
  endfunction

  function automatic logic [6:0] exp_secret(logic [1:0] d, logic [6:0] l);
    case (d)
      2'd1:    return {3'b000, l[3:0]};
      2'd2:    return {1'b0, l[5:0]};
      default: return (l > 7'd99) ? l - 7'd28 : l;
    endcase
  endfunction

  task automatic push(input string name, input string sig, input int exp);
    sb_entry_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    int obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_assert++;
      assert (obs === e.exp)
        else begin
          n_fail++;
          $error("FAIL %s: observed %0d expected %0d", e.name, obs, e.exp);
        end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse -> LOAD cycle -> first PLAY cycle, checking both.
  task automatic start_round(input logic [1:0] d, output logic [6:0] s_exp);
    Max_digit = d;
    start     = 1'b1;
    push("load_restart_low", "restart", 0);
    push("load_timer_digit", "timer_digit", int'(d));
    tick();
    start = 1'b0;
    drain();
    s_exp = exp_secret(d, m_lfsr);
    push("play_restart_high", "restart", 1);
    push("play_secret", "secret", int'(s_exp));
    push("play_attempts_clear", "attempts", 0);
    push("play_timeout_clear", "timeout", 0);
    push("play_hint_hi_clear", "hint_hi", 0);
    tick();
    drain();
  endtask

  task automatic do_guess(input logic [6:0] g, input logic [6:0] c);
    guess       = g;
    counter     = c;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] s;
    logic [6:0] nx;
    bit         found;
    int         sc;

    reset = 1'b1; start = 1'b0; guess_valid = 1'b0;
    Max_digit = 2'd0; guess = 7'd0; counter = 7'd50;
    tick(); tick();
    push("rst_restart", "restart", 1);
    push("rst_timer_digit", "timer_digit", 0);
    push("rst_secret", "secret", 0);
    push("rst_score", "score", 0);
    push("rst_attempts", "attempts", 0);
    push("rst_win", "win", 0);
    push("rst_lose", "lose", 0);
    push("rst_timeout", "timeout", 0);
    drain();
    reset = 1'b0;

    // start with difficulty 0 is ignored
    start = 1'b1;
    push("zero_digit_no_load", "restart", 1);
    push("zero_digit_timer", "timer_digit", 0);
    tick();
    start = 1'b0;
    drain();

    // Wait for an LFSR phase giving a secret in 1..14 so S-1 and S+1 are
    // both meaningful hints.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      nx = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      if (nx[3:0] >= 4'd1 && nx[3:0] <= 4'd14) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_assert++;
    assert (found)
      else begin
        n_fail++;
        $error("FAIL lfsr_phase_search: observed 0 expected 1");
      end

    // Round 1: difficulty 1, hints then win
    start_round(2'd1, s);
    push("g1_hint_hi", "hint_hi", 1);
    push("g1_hint_lo", "hint_lo", 0);
    push("g1_attempts", "attempts", 1);
    do_guess(s + 7'd1, 7'd20);
    drain();
    push("g2_hint_hi", "hint_hi", 0);
    push("g2_hint_lo", "hint_lo", 1);
    push("g2_attempts", "attempts", 2);
    do_guess(s - 7'd1, 7'd20);
    drain();
    push("g3_win", "win", 1);
    push("g3_attempts", "attempts", 2);
    push("g3_score", "score", 20);
    push("g3_hint_lo_held", "hint_lo", 1);
    do_guess(s, 7'd20);
    drain();
    counter = 7'd50;
    sc = 20;

    // Round 2: difficulty 2, eight wrong guesses
    start_round(2'd2, s);
    for (int i = 0; i < 7; i++) do_guess(s ^ 7'd1, 7'd50);
    push("w7_still_playing", "lose", 0);
    push("w7_attempts", "attempts", 7);
    drain();
    push("w8_lose", "lose", 1);
    push("w8_timeout", "timeout", 0);
    push("w8_attempts", "attempts", 8);
    do_guess(s ^ 7'd1, 7'd50);
    drain();
    push("after_lose_held", "lose", 1);
    push("after_lose_score", "score", sc);
    push("after_lose_attempts", "attempts", 8);
    do_guess(s, 7'd50);
    drain();

    // Round 3: difficulty 3, timer runs out
    start_round(2'd3, s);
    Max_digit = 2'd1;
    start     = 1'b1;
    counter   = 7'd90;
    push("play_start_ignored", "restart", 1);
    push("play_digit_held", "timer_digit", 3);
    push("play_secret_held", "secret", int'(s));
    tick();
    start = 1'b0;
    drain();
    for (int c = 89; c >= 1; c--) begin
      counter = 7'(c);
      if (c == 1) push("count1_not_lost", "lose", 0);
      tick();
      drain();
    end
    counter = 7'd0;
    push("to_lose", "lose", 1);
    push("to_timeout", "timeout", 1);
    push("to_score", "score", sc);
    tick();
    drain();
    counter = 7'd50;

    // Round 4: correct guess coincides with counter == 0
    start_round(2'd1, s);
    push("tie_win", "win", 1);
    push("tie_timeout", "timeout", 0);
    push("tie_score", "score", sc);
    do_guess(s, 7'd0);
    drain();
    counter = 7'd50;

    // Repeated wins at counter 90 saturate the score
    for (int r = 0; r < 3; r++) begin
      start_round(2'd2, s);
      sc = (sc + 90 > 255) ? 255 : sc + 90;
      push("sat_win", "win", 1);
      push("sat_score", "score", sc);
      do_guess(s, 7'd90);
      drain();
    end
    counter = 7'd50;

    // Reset mid-PLAY, with a winning guess on the same edge
    start_round(2'd1, s);
    reset = 1'b1;
    push("midrst_restart", "restart", 1);
    push("midrst_score", "score", 0);
    push("midrst_win", "win", 0);
    push("midrst_timer_digit", "timer_digit", 0);
    push("midrst_secret", "secret", 0);
    do_guess(s, 7'd90);
    drain();
    reset = 1'b0;
    tick();
    push("idle_after_rst", "restart", 1);
    push("idle_after_rst_lose", "lose", 0);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  single-cycle pulse that begins a round.
REQ-004 SHALL have ports: Max_digit  in  2  difficulty (1, 2 or 3); 0 is invalid.
REQ-005 SHALL have ports: guess  in  7  player guess, unsigned.
REQ-006 SHALL have ports: guess_valid  in  1  single-cycle pulse qualifying guess.
REQ-007 SHALL have ports: counter  in  7  remaining seconds from the downstream countdown timer.
REQ-008 SHALL have ports: restart  out  1  active-low timer reload; timer reloads its difficulty maximum while low.
REQ-009 SHALL have ports: timer_digit  out  2  latched difficulty driven to the timer's Max_digit.
REQ-010 SHALL have ports: hint_hi / hint_lo  out  1 each  last wrong guess above / below secret.
REQ-011 SHALL have ports: win, lose, timeout  out  1 each  round result flags.
REQ-012 SHALL have ports: attempts  out  4  wrong guesses this round.
REQ-013 SHALL have ports: score  out  8  accumulated score.
REQ-014 SHALL have ports: secret  out  7  current secret (debug/verification).

Function
REQ-015 SHALL run a free-running 7-bit LFSR every cycle: next = {lfsr[5:0], lfsr[6]^lfsr[5]}, seed 7'h01.
REQ-016 SHALL use states IDLE, LOAD, PLAY, WIN, LOSE.
REQ-017 IDLE: start with Max_digit!=0 -> LOAD; start with Max_digit==0 is ignored.
REQ-018 LOAD lasts exactly one cycle: latch difficulty into timer_digit, latch secret, clear attempts/hints/win/lose/timeout, -> PLAY.
REQ-019 Secret derivation from LFSR value L at LOAD: difficulty 1 -> {3'b0,L[3:0]} (0..15); 2 -> {1'b0,L[5:0]} (0..63); 3 -> L>99 ? L-28 : L (0..99).
REQ-020 restart SHALL be 0 only while state==LOAD, else 1 (combinational from state), so the first PLAY cycle sees counter = timer maximum.
REQ-021 PLAY, guess_valid and guess==secret -> WIN; score += counter, saturating at 255.
REQ-022 PLAY, guess_valid and guess!=secret: hint_hi = (guess>secret), hint_lo = (guess<secret), attempts+1; if new attempts==8 -> LOSE.
REQ-023 PLAY, no guess_valid and counter==0 -> LOSE with timeout=1.
REQ-024 Same-cycle correct guess and counter==0: WIN has priority; timeout stays 0.
REQ-025 Same-cycle wrong 8th guess and counter==0: LOSE, timeout=0.
REQ-026 start during LOAD or PLAY SHALL be ignored; Max_digit changes after LOAD SHALL NOT affect timer_digit or secret.
REQ-027 WIN/LOSE hold all outputs; start with Max_digit!=0 -> LOAD (new round, score retained).
REQ-028 win=1 only in WIN, lose=1 only in LOSE; hints registered, held until next wrong guess or LOAD.

Reset
REQ-029 reset SHALL override all inputs: state IDLE, LFSR 7'h01, secret 0, timer_digit 0, attempts 0, score 0, hints/win/lose/timeout 0, restart 1.
REQ-030 reset asserted mid-round SHALL abandon the round at the next edge with no score update.

Verification
REQ-031 reset, start with Max_digit=1 -> restart low exactly one cycle, timer_digit=1, secret<=15, PLAY next.
REQ-032 secret=S, guess S+1 then S-1 then S with counter=20 -> hint_hi, then hint_lo, then win=1, attempts=2, score=20.
REQ-033 Eight wrong guesses, counter>0 -> lose=1, timeout=0, attempts=8; further guess_valid ignored.
REQ-034 Max_digit=3, no guesses, counter falls 90..0 -> lose=1, timeout=1 on the cycle after counter==0; secret<=99.
REQ-035 Correct guess coincident with counter==0 -> win=1, timeout=0, score unchanged by the zero add.
REQ-036 Repeated wins with counter=90 -> score saturates at 255; reset mid-PLAY -> IDLE, score 0, restart 1.
